// File: rtl/ysyx_23060201_lsu.sv
// rtl/ysyx_23060201_lsu.sv - load/store unit between EXU and the data-memory stage
`timescale 1ns/1ps
module ysyx_23060201_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [4:0]            resp_rd,
   output logic                  resp_err,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic [7:0]            mem_rmask,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [7:0]            mem_wmask,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state, state_next;

   logic [1:0]            op_off;
   logic [2:0]            op_funct3;
   logic                  op_wen;

   logic [1:0]            req_off;
   logic                  req_illegal;
   logic                  req_misaligned;
   logic                  req_err;
   logic [7:0]            req_mask;
   logic [DATA_WIDTH-1:0] req_wdata_rep;
   logic [DATA_WIDTH-1:0] ld_shifted;
   logic [DATA_WIDTH-1:0] ld_data;

   assign req_off    = req_addr[1:0];
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   // Request decode: legality, alignment, lane mask and lane-replicated store data.
   always_comb begin
      req_misaligned = 1'b0;
      req_mask       = 8'h0F;
      req_wdata_rep  = req_wdata;
      if (req_wen) begin
         req_illegal = (req_funct3 > 3'b010);
      end else begin
         req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      end
      case (req_funct3[1:0])
         2'b00: begin
            req_mask      = 8'h01 << req_off;
            req_wdata_rep = {(DATA_WIDTH/8){req_wdata[7:0]}};
         end
         2'b01: begin
            req_misaligned = req_off[0];
            req_mask       = 8'h03 << req_off;
            req_wdata_rep  = {(DATA_WIDTH/16){req_wdata[15:0]}};
         end
         default: begin
            req_misaligned = (req_off != 2'b00);
         end
      endcase
      req_err = req_illegal || req_misaligned;
   end

   always_comb begin
      ld_shifted = mem_rdata >> {op_off, 3'b000};
      case (op_funct3)
         3'b000:  ld_data = {{(DATA_WIDTH-8){ld_shifted[7]}}, ld_shifted[7:0]};
         3'b001:  ld_data = {{(DATA_WIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
         3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_shifted[7:0]};
         3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_shifted[15:0]};
         default: ld_data = ld_shifted;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
         ACCESS:  state_next = op_wen ? RESP : WAIT;
         WAIT:    state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Enables default low so each access pulse lasts exactly the ACCESS cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_off    <= '0;
         op_funct3 <= '0;
         op_wen    <= 1'b0;
         resp_data <= '0;
         resp_rd   <= '0;
         resp_err  <= 1'b0;
         mem_ren   <= 1'b0;
         mem_raddr <= '0;
         mem_rmask <= '0;
         mem_wen   <= 1'b0;
         mem_waddr <= '0;
         mem_wmask <= '0;
         mem_wdata <= '0;
      end else begin
         mem_ren <= 1'b0;
         mem_wen <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_off    <= req_off;
                  op_funct3 <= req_funct3;
                  op_wen    <= req_wen;
                  resp_rd   <= req_rd;
                  resp_data <= '0;
                  resp_err  <= req_err;
                  if (!req_err && req_wen) begin
                     mem_wen   <= 1'b1;
                     mem_waddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_wmask <= req_mask;
                     mem_wdata <= req_wdata_rep;
                  end else if (!req_err) begin
                     mem_ren   <= 1'b1;
                     mem_raddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_rmask <= req_mask;
                  end
               end
            end
            WAIT: begin
               resp_data <= ld_data;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_data <= '0;
                  resp_err  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// tb/tb_ysyx_23060201_lsu.sv - directed self-checking bench for ysyx_23060201_lsu
`timescale 1ns/1ps
module tb_ysyx_23060201_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [7:0]  mem_rmask, mem_wmask;

   int checks   = 0;
   int failures = 0;
   int ren_cnt  = 0;
   int wen_cnt  = 0;
   int both_cnt = 0;
   int exp_ren  = 0;
   int exp_wen  = 0;

   always #5 clk = ~clk;

   ysyx_23060201_lsu dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(negedge clk) begin
      if (mem_ren) ren_cnt++;
      if (mem_wen) wen_cnt++;
      if (mem_ren && mem_wen) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
      req_valid  = 1'b1;
      req_wen    = wen;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      req_rd     = rd;
      check("req_ready_before_accept", req_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check("after_hs_resp_valid", resp_valid, 1'b0);
      check("after_hs_resp_data", resp_data, 32'h0);
      check("after_hs_resp_err", resp_err, 1'b0);
      check("after_hs_req_ready", req_ready, 1'b1);
   endtask

   task automatic load_case(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] raddr, input logic [7:0] mask,
                            input logic [31:0] data, input logic [4:0] rd);
      do_req(1'b0, f3, addr, 32'h0, rd);
      exp_ren++;
      check("ld_s1_mem_ren", mem_ren, 1'b1);
      check("ld_s1_raddr", mem_raddr, raddr);
      check("ld_s1_rmask", {24'h0, mem_rmask}, {24'h0, mask});
      check("ld_s1_resp_valid", resp_valid, 1'b0);
      step();
      check("ld_s2_mem_ren", mem_ren, 1'b0);
      check("ld_s2_resp_valid", resp_valid, 1'b0);
      step();
      check("ld_s3_resp_valid", resp_valid, 1'b1);
      check("ld_s3_resp_data", resp_data, data);
      check("ld_s3_resp_err", resp_err, 1'b0);
      check("ld_s3_resp_rd", {27'h0, resp_rd}, {27'h0, rd});
      finish_resp();
   endtask

   task automatic store_case(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] waddr, input logic [7:0] mask,
                             input logic [31:0] mdata, input logic [4:0] rd);
      do_req(1'b1, f3, addr, wdata, rd);
      exp_wen++;
      check("st_s1_mem_wen", mem_wen, 1'b1);
      check("st_s1_mem_ren", mem_ren, 1'b0);
      check("st_s1_waddr", mem_waddr, waddr);
      check("st_s1_wmask", {24'h0, mem_wmask}, {24'h0, mask});
      check("st_s1_wdata", mem_wdata, mdata);
      check("st_s1_resp_valid", resp_valid, 1'b0);
      step();
      check("st_s2_mem_wen", mem_wen, 1'b0);
      check("st_s2_resp_valid", resp_valid, 1'b1);
      check("st_s2_resp_data", resp_data, 32'h0);
      check("st_s2_resp_err", resp_err, 1'b0);
      check("st_s2_resp_rd", {27'h0, resp_rd}, {27'h0, rd});
      finish_resp();
   endtask

   task automatic err_case(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd);
      do_req(wen, f3, addr, 32'hFFFFFFFF, rd);
      check("err_resp_valid", resp_valid, 1'b1);
      check("err_resp_err", resp_err, 1'b1);
      check("err_resp_data", resp_data, 32'h0);
      check("err_resp_rd", {27'h0, resp_rd}, {27'h0, rd});
      check("err_mem_ren", mem_ren, 1'b0);
      check("err_mem_wen", mem_wen, 1'b0);
      finish_resp();
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_rd     = 5'd0;
      resp_ready = 1'b0;
      mem_rdata  = 32'h8070F0FF;
      step();
      step();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_mem_ren", mem_ren, 1'b0);
      check("rst_mem_wen", mem_wen, 1'b0);
      rst = 1'b0;
      step();

      store_case(3'b010, 32'h80000004, 32'hDEADBEEF, 32'h80000004, 8'h0F, 32'hDEADBEEF, 5'd5);
      store_case(3'b000, 32'h80000003, 32'h000000A5, 32'h80000000, 8'h08, 32'hA5A5A5A5, 5'd6);
      store_case(3'b001, 32'h80000002, 32'h1234BEEF, 32'h80000000, 8'h0C, 32'hBEEFBEEF, 5'd7);

      load_case(3'b000, 32'h80000001, 32'h80000000, 8'h02, 32'hFFFFFFF0, 5'd1);
      load_case(3'b100, 32'h80000001, 32'h80000000, 8'h02, 32'h000000F0, 5'd2);
      load_case(3'b000, 32'h80000002, 32'h80000000, 8'h04, 32'h00000070, 5'd3);
      load_case(3'b101, 32'h80000002, 32'h80000000, 8'h0C, 32'h00008070, 5'd4);
      load_case(3'b010, 32'h80000008, 32'h80000008, 8'h0F, 32'h8070F0FF, 5'd8);

      err_case(1'b0, 3'b010, 32'h80000002, 5'd17);
      err_case(1'b0, 3'b011, 32'h80000000, 5'd18);
      err_case(1'b0, 3'b110, 32'h80000000, 5'd19);
      err_case(1'b1, 3'b100, 32'h80000000, 5'd20);
      err_case(1'b1, 3'b001, 32'h80000001, 5'd21);

      // LH with back-pressure, then a request overlapping the handshake cycle
      do_req(1'b0, 3'b001, 32'h80000002, 32'h0, 5'd9);
      exp_ren++;
      check("lh_s1_rmask", {24'h0, mem_rmask}, 32'h0000000C);
      check("lh_s1_resp_valid", resp_valid, 1'b0);
      step();
      check("lh_s2_resp_valid", resp_valid, 1'b0);
      step();
      check("lh_s3_resp_valid", resp_valid, 1'b1);
      check("lh_s3_resp_data", resp_data, 32'hFFFF8070);
      req_valid  = 1'b1;
      req_wen    = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h80000000;
      req_rd     = 5'd10;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_resp_valid", resp_valid, 1'b1);
         check("bp_resp_data", resp_data, 32'hFFFF8070);
         check("bp_resp_rd", {27'h0, resp_rd}, 32'd9);
         check("bp_req_ready", req_ready, 1'b0);
         check("bp_mem_ren", mem_ren, 1'b0);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("hs_resp_valid", resp_valid, 1'b0);
      check("hs_req_ready", req_ready, 1'b1);
      check("hs_mem_ren", mem_ren, 1'b0);
      step();
      req_valid = 1'b0;
      exp_ren++;
      check("next_mem_ren", mem_ren, 1'b1);
      check("next_rmask", {24'h0, mem_rmask}, 32'h0000000F);
      step();
      step();
      check("next_resp_valid", resp_valid, 1'b1);
      check("next_resp_data", resp_data, 32'h8070F0FF);
      check("next_resp_rd", {27'h0, resp_rd}, 32'd10);
      finish_resp();

      // Asynchronous reset in the middle of a load access
      do_req(1'b0, 3'b010, 32'h80000000, 32'h0, 5'd11);
      exp_ren++;
      check("ar_mem_ren_before", mem_ren, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("ar_mem_ren_async", mem_ren, 1'b0);
      check("ar_resp_valid_async", resp_valid, 1'b0);
      step();
      step();
      rst = 1'b0;
      check("ar_req_ready", req_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("ar_resp_valid_after", resp_valid, 1'b0);
      end

      check("ren_pulse_count", ren_cnt, exp_ren);
      check("wen_pulse_count", wen_cnt, exp_wen);
      check("ren_wen_overlap", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
